// File: rtl/cache_front_end_wq_pkg.sv
// Shared encodings for the cache front-end: FE request FSM and data-port arbiter states,
// plus the default cache-control address width used by cache control as well.
package cache_front_end_wq_pkg;

  localparam int CTRL_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RD   = 2'd1,
    F_CTRL = 2'd2,
    F_RESP = 2'd3
  } fe_state_t;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_WRITE = 2'd1,
    D_READ  = 2'd2
  } d_state_t;

endpackage

// File: rtl/cache_front_end_wq_fe_write_queue.sv
// Posted-write FIFO for the cache front-end: circular storage, head outputs and a
// per-entry address match used to detect read-after-write hazards.
module fe_write_queue
  import cache_front_end_wq_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int NBYTES = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [NBYTES-1:0] push_strb,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [NBYTES-1:0] head_strb,
  output logic              empty,
  output logic              full,
  input  logic [ADDR_W-1:0] match_addr,
  output logic [DEPTH-1:0]  match
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [NBYTES-1:0] q_strb [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= push_addr;
      q_data[wr_ptr] <= push_data;
      q_strb[wr_ptr] <= push_strb;
    end
  end

  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign head_strb = q_strb[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));

  // An entry is live when its distance from the head is below the count; the head
  // stays live while it is being written out, so an in-flight write still blocks.
  always_comb begin
    match = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr;
      if (({1'b0, off} < count) && (q_addr[i] == match_addr)) match[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cache_front_end_wq.sv
// Cache front-end: routes CPU requests to cache memory or cache control, posts writes
// through a write queue and stalls reads only on a true address hazard.
//  state   | meaning
//  F_IDLE  | accept a request
//  F_RD    | read latched, waiting for arbiter issue and data_ready
//  F_CTRL  | cache-control access outstanding
//  F_RESP  | one-cycle ready pulse
//  D_IDLE  | data port free
//  D_WRITE | queue head on the data port
//  D_READ  | front-end read on the data port
module cache_front_end_wq
  import cache_front_end_wq_pkg::*;
#(
  parameter int FE_ADDR_W   = 32,
  parameter int FE_DATA_W   = 32,
  parameter int WQ_DEPTH    = 4,
  parameter int CTRL_CACHE  = 0,
  parameter int CTRL_ADDR_W = CTRL_ADDR_W_DEF,
  parameter int WORD_ADDR   = 0,
  localparam int FE_NBYTES  = FE_DATA_W / 8,
  localparam int FE_BYTES_W = $clog2(FE_NBYTES),
  localparam int IN_ADDR_W  = CTRL_CACHE + FE_ADDR_W - ((WORD_ADDR != 0) ? FE_BYTES_W : 0),
  localparam int WADDR_W    = FE_ADDR_W - FE_BYTES_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [IN_ADDR_W-1:0]   addr,
  input  logic [FE_DATA_W-1:0]   wdata,
  input  logic [FE_NBYTES-1:0]   wstrb,
  output logic                   ready,
  output logic [FE_DATA_W-1:0]   rdata,
  output logic                   data_valid,
  output logic [WADDR_W-1:0]     data_addr,
  output logic [FE_DATA_W-1:0]   data_wdata,
  output logic [FE_NBYTES-1:0]   data_wstrb,
  input  logic [FE_DATA_W-1:0]   data_rdata,
  input  logic                   data_ready,
  output logic                   ctrl_valid,
  output logic [CTRL_ADDR_W-1:0] ctrl_addr,
  input  logic [FE_DATA_W-1:0]   ctrl_rdata,
  input  logic                   ctrl_ready,
  output logic                   wq_empty,
  output logic                   wq_full
);

  localparam int CA_LSB = (WORD_ADDR != 0) ? 0 : FE_BYTES_W;

  fe_state_t fe_state, fe_next;
  d_state_t  d_state, d_next;

  logic [WADDR_W-1:0]   in_waddr, rd_addr;
  logic [WADDR_W-1:0]   head_addr;
  logic [FE_DATA_W-1:0] head_data;
  logic [FE_NBYTES-1:0] head_strb;
  logic [WQ_DEPTH-1:0]  raw_match;
  logic ctrl_sel, push, pop, latch_rd, ctrl_start, ctrl_done;
  logic issue_rd, issue_wr, rd_done;
  logic unused_bits;

  if (WORD_ADDR != 0) begin : g_word_addr
    assign in_waddr = addr[WADDR_W-1:0];
  end else begin : g_byte_addr
    assign in_waddr = addr[FE_BYTES_W +: WADDR_W];
  end

  assign unused_bits = ^addr;
  assign ctrl_sel    = (CTRL_CACHE != 0) && addr[IN_ADDR_W-1];
  assign ready       = (fe_state == F_RESP);

  fe_write_queue #(
    .ADDR_W (WADDR_W),
    .DATA_W (FE_DATA_W),
    .NBYTES (FE_NBYTES),
    .DEPTH  (WQ_DEPTH)
  ) u_wq (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (in_waddr),
    .push_data  (wdata),
    .push_strb  (wstrb),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .head_strb  (head_strb),
    .empty      (wq_empty),
    .full       (wq_full),
    .match_addr (rd_addr),
    .match      (raw_match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_state <= F_IDLE;
      d_state  <= D_IDLE;
    end else begin
      fe_state <= fe_next;
      d_state  <= d_next;
    end
  end

  always_comb begin
    fe_next    = fe_state;
    push       = 1'b0;
    latch_rd   = 1'b0;
    ctrl_start = 1'b0;
    ctrl_done  = 1'b0;
    case (fe_state)
      F_IDLE: if (valid) begin
        if (ctrl_sel) begin
          if (wq_empty) begin
            ctrl_start = 1'b1;
            fe_next    = F_CTRL;
          end
        end else if (|wstrb) begin
          if (!wq_full) begin
            push    = 1'b1;
            fe_next = F_RESP;
          end
        end else begin
          latch_rd = 1'b1;
          fe_next  = F_RD;
        end
      end
      F_RD:   if (rd_done) fe_next = F_RESP;
      F_CTRL: if (ctrl_ready) begin
        ctrl_done = 1'b1;
        fe_next   = F_RESP;
      end
      default: fe_next = F_IDLE;
    endcase
  end

  // A pending read wins over draining when both could start on the same edge.
  always_comb begin
    d_next   = d_state;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    pop      = 1'b0;
    rd_done  = 1'b0;
    case (d_state)
      D_IDLE: begin
        if ((fe_state == F_RD) && !(|raw_match)) begin
          issue_rd = 1'b1;
          d_next   = D_READ;
        end else if (!wq_empty) begin
          issue_wr = 1'b1;
          d_next   = D_WRITE;
        end
      end
      D_WRITE: if (data_ready) begin
        pop    = 1'b1;
        d_next = D_IDLE;
      end
      D_READ: if (data_ready) begin
        rd_done = 1'b1;
        d_next  = D_IDLE;
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      rdata      <= '0;
      ctrl_valid <= 1'b0;
      ctrl_addr  <= '0;
      data_valid <= 1'b0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
    end else begin
      if (latch_rd) rd_addr <= in_waddr;
      if (ctrl_start) begin
        ctrl_valid <= 1'b1;
        ctrl_addr  <= addr[CA_LSB +: CTRL_ADDR_W];
      end
      if (ctrl_done) begin
        ctrl_valid <= 1'b0;
        rdata      <= ctrl_rdata;
      end
      if (rd_done) rdata <= data_rdata;
      if (issue_rd) begin
        data_valid <= 1'b1;
        data_addr  <= rd_addr;
        data_wdata <= '0;
        data_wstrb <= '0;
      end else if (issue_wr) begin
        data_valid <= 1'b1;
        data_addr  <= head_addr;
        data_wdata <= head_data;
        data_wstrb <= head_strb;
      end else if (pop || rd_done) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_front_end_wq.sv
// Directed bench for cache_front_end_wq: posted writes, queue full, RAW stall, read
// bypass, cache-control ordering and reset during a queued drain.
module tb_cache_front_end_wq;

  logic        clk, reset, valid;
  logic [32:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;
  logic        data_valid;
  logic [29:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        ctrl_valid;
  logic [4:0]  ctrl_addr;
  logic [31:0] ctrl_rdata;
  logic        ctrl_ready;
  logic        wq_empty, wq_full;
  int          checks, errors;

  cache_front_end_wq #(
    .FE_ADDR_W   (32),
    .FE_DATA_W   (32),
    .WQ_DEPTH    (4),
    .CTRL_CACHE  (1),
    .CTRL_ADDR_W (5),
    .WORD_ADDR   (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .addr       (addr),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .ready      (ready),
    .rdata      (rdata),
    .data_valid (data_valid),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_wstrb (data_wstrb),
    .data_rdata (data_rdata),
    .data_ready (data_ready),
    .ctrl_valid (ctrl_valid),
    .ctrl_addr  (ctrl_addr),
    .ctrl_rdata (ctrl_rdata),
    .ctrl_ready (ctrl_ready),
    .wq_empty   (wq_empty),
    .wq_full    (wq_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write request issued from an idle front end; lat = negedges until ready, -1 on timeout.
  task automatic req(input logic [32:0] a, input logic [31:0] d, input logic [3:0] s,
                     output int lat);
    valid = 1'b1; addr = a; wdata = d; wstrb = s; lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 10);
    if (!ready) lat = -1;
    valid = 1'b0; wstrb = 4'h0;
    @(negedge clk);
  endtask

  task automatic drain_one(input string tag, input logic [29:0] ea, input logic [31:0] ed);
    int n;
    n = 0;
    while (!data_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(data_valid), 64'h1);
    chk({tag, "_addr"}, 64'(data_addr), 64'(ea));
    chk({tag, "_data"}, 64'(data_wdata), 64'(ed));
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    int lat, n;
    checks = 0; errors = 0;
    reset = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    data_rdata = '0; data_ready = 1'b0; ctrl_rdata = '0; ctrl_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_data_valid", 64'(data_valid), 64'h0);
    chk("rst_ctrl_valid", 64'(ctrl_valid), 64'h0);
    chk("rst_wq_empty", 64'(wq_empty), 64'h1);
    chk("rst_wq_full", 64'(wq_full), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);

    // single posted write, data port stalled
    req(33'h10, 32'hAA, 4'hF, lat);
    chk("w1_lat", 64'(lat), 64'h1);
    chk("w1_wq_empty", 64'(wq_empty), 64'h0);
    chk("w1_data_valid", 64'(data_valid), 64'h1);
    chk("w1_data_addr", 64'(data_addr), 64'h4);
    chk("w1_data_wstrb", 64'(data_wstrb), 64'hF);
    repeat (2) @(negedge clk);
    chk("w1_held", 64'({data_valid, data_addr}), 64'({1'b1, 30'h4}));
    drain_one("w1_drain", 30'h4, 32'hAA);
    chk("w1_after_valid", 64'(data_valid), 64'h0);
    chk("w1_after_empty", 64'(wq_empty), 64'h1);

    // fill the queue, fifth write blocks until a pop
    for (int i = 0; i < 4; i++) begin
      req(33'h100 + 33'(4 * i), 32'hD0 + 32'(i), 4'hF, lat);
      chk("fill_lat", 64'(lat), 64'h1);
    end
    chk("fill_full", 64'(wq_full), 64'h1);
    valid = 1'b1; addr = 33'h110; wdata = 32'hD4; wstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("full_no_ready", 64'(ready), 64'h0);
    end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("full_after_pop", 64'(wq_full), 64'h0);
    chk("full_still_wait", 64'(ready), 64'h0);
    n = 0;
    while (!ready && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("fifth_lat", 64'(n), 64'h1);
    valid = 1'b0; wstrb = 4'h0;
    @(negedge clk);
    drain_one("fifo1", 30'h41, 32'hD1);
    drain_one("fifo2", 30'h42, 32'hD2);
    drain_one("fifo3", 30'h43, 32'hD3);
    drain_one("fifo4", 30'h44, 32'hD4);
    chk("fifo_empty", 64'(wq_empty), 64'h1);

    // read latency with an empty queue
    valid = 1'b1; addr = 33'h44; wstrb = 4'h0;
    @(negedge clk);
    chk("rd_t1_valid", 64'(data_valid), 64'h0);
    @(negedge clk);
    chk("rd_t2_valid", 64'(data_valid), 64'h1);
    chk("rd_t2_addr", 64'(data_addr), 64'h11);
    chk("rd_t2_wstrb", 64'(data_wstrb), 64'h0);
    data_rdata = 32'h600D_F00D; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0; valid = 1'b0;
    chk("rd_ready", 64'(ready), 64'h1);
    chk("rd_rdata", 64'(rdata), 64'h600D_F00D);
    @(negedge clk);
    chk("rd_ready_pulse", 64'(ready), 64'h0);

    // RAW: read of a queued write address waits for that write
    req(33'h20, 32'h1234, 4'hF, lat);
    chk("raw_w_lat", 64'(lat), 64'h1);
    valid = 1'b1; addr = 33'h20; wstrb = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("raw_stall", 64'({ready, data_wstrb}), 64'({1'b0, 4'hF}));
    end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("raw_gap", 64'(data_valid), 64'h0);
    @(negedge clk);
    chk("raw_rd_issue", 64'({data_valid, data_wstrb, data_addr}), 64'({1'b1, 4'h0, 30'h8}));
    data_rdata = 32'h1234_5678; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0; valid = 1'b0;
    chk("raw_ready", 64'(ready), 64'h1);
    chk("raw_rdata", 64'(rdata), 64'h1234_5678);
    @(negedge clk);

    // non-matching read bypasses a queued write
    req(33'h40, 32'h11, 4'hF, lat);
    req(33'h20, 32'h22, 4'hF, lat);
    valid = 1'b1; addr = 33'h30; wstrb = 4'h0;
    @(negedge clk);
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("byp_gap", 64'(data_valid), 64'h0);
    @(negedge clk);
    chk("byp_rd_issue", 64'({data_valid, data_wstrb, data_addr}), 64'({1'b1, 4'h0, 30'hC}));
    data_rdata = 32'hBEEF; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0; valid = 1'b0;
    chk("byp_ready", 64'(ready), 64'h1);
    chk("byp_rdata", 64'(rdata), 64'hBEEF);
    @(negedge clk);
    drain_one("byp_drain", 30'h8, 32'h22);
    chk("byp_empty", 64'(wq_empty), 64'h1);

    // cache-control access waits for an empty queue
    req(33'h50, 32'h99, 4'hF, lat);
    valid = 1'b1; addr = 33'h1_0000_000C; wstrb = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("ctrl_wait", 64'(ctrl_valid), 64'h0);
    end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    chk("ctrl_q_empty", 64'(wq_empty), 64'h1);
    chk("ctrl_not_yet", 64'(ctrl_valid), 64'h0);
    n = 0;
    while (!ctrl_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("ctrl_lat", 64'(n), 64'h1);
    chk("ctrl_addr", 64'(ctrl_addr), 64'h3);
    chk("ctrl_no_data", 64'(data_valid), 64'h0);
    ctrl_rdata = 32'h5; ctrl_ready = 1'b1;
    @(negedge clk);
    ctrl_ready = 1'b0; valid = 1'b0;
    chk("ctrl_ready", 64'(ready), 64'h1);
    chk("ctrl_rdata", 64'(rdata), 64'h5);
    chk("ctrl_valid_drop", 64'(ctrl_valid), 64'h0);
    @(negedge clk);

    // reset while a write is on the data port with three queued
    req(33'h200, 32'hE0, 4'hF, lat);
    req(33'h204, 32'hE1, 4'hF, lat);
    req(33'h208, 32'hE2, 4'hF, lat);
    chk("pre_rst_busy", 64'({data_valid, wq_empty}), 64'({1'b1, 1'b0}));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 64'(ready), 64'h0);
    chk("mid_rst_data_valid", 64'(data_valid), 64'h0);
    chk("mid_rst_data_bus", 64'({data_addr, data_wdata, data_wstrb}), 64'h0);
    chk("mid_rst_rdata", 64'(rdata), 64'h0);
    chk("mid_rst_ctrl", 64'({ctrl_valid, ctrl_addr}), 64'h0);
    chk("mid_rst_flags", 64'({wq_empty, wq_full}), 64'({1'b1, 1'b0}));
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(data_valid), 64'h0);
    end
    req(33'h300, 32'h77, 4'hF, lat);
    chk("post_rst_lat", 64'(lat), 64'h1);
    drain_one("post_rst_drain", 30'hC0, 32'h77);
    chk("post_rst_empty", 64'(wq_empty), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
